// File: rtl/n3_parser_port_scheduler.sv
// Round-robin arbiter sharing one N3 GTP-U parser among NUM_PORTS requesters:
// streams the granted packet onto the parser bus and returns its PHS tagged with the port.
module n3_parser_port_scheduler #(
    parameter int NUM_PORTS  = 4,
    parameter int GAP_CYCLES = 2,
    parameter int LEN_W      = 16,
    localparam int PW        = $clog2(NUM_PORTS)
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [NUM_PORTS-1:0]       req_i,
    input  logic [NUM_PORTS*LEN_W-1:0] pkt_len_i,
    input  logic [NUM_PORTS*32-1:0]    data_i,
    output logic [NUM_PORTS-1:0]       rd_o,
    output logic [31:0]                bus_o,
    output logic                       sop_o,
    input  logic [119:0]               phs_i,
    input  logic                       phs_valid_i,
    output logic [119:0]               phs_o,
    output logic [PW-1:0]              phs_port_o,
    output logic                       phs_valid_o,
    output logic                       err_nophs_o,
    output logic                       busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     grant_q, last_q, winner, idx;
    logic [LEN_W-1:0]  len_q, cnt_q, win_len;
    logic              phs_seen_q;
    logic              found, stream_last, gap_last, capture, no_phs;

    // Rotating search: start one past the last winner, first requester found wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = PW'((int'(last_q) + i) % NUM_PORTS);
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        win_len = pkt_len_i[int'(winner)*LEN_W +: LEN_W];
        if (win_len == '0) begin
            win_len = LEN_W'(1);
        end
    end

    assign stream_last = (cnt_q == len_q - LEN_W'(1));
    assign gap_last    = (cnt_q == LEN_W'(GAP_CYCLES - 1));
    assign capture     = (state_q != IDLE) && phs_valid_i && !phs_seen_q;
    assign no_phs      = (state_q == GAP) && gap_last && !phs_seen_q && !phs_valid_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found)       state_d = STREAM;
            STREAM:  if (stream_last) state_d = GAP;
            GAP:     if (gap_last)    state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Word handshake: while streaming, the granted port must hold a valid head word;
    // rd_o pops it in the same cycle it is driven onto bus_o (no back-pressure).
    always_comb begin
        bus_o  = '0;
        rd_o   = '0;
        sop_o  = 1'b0;
        busy_o = (state_q != IDLE);
        if (state_q == STREAM) begin
            bus_o         = data_i[int'(grant_q)*32 +: 32];
            rd_o[grant_q] = 1'b1;
            sop_o         = (cnt_q == '0);
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= PW'(NUM_PORTS - 1);
            len_q       <= '0;
            cnt_q       <= '0;
            phs_seen_q  <= 1'b0;
            phs_o       <= '0;
            phs_port_o  <= '0;
            phs_valid_o <= 1'b0;
            err_nophs_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            phs_valid_o <= capture;
            err_nophs_o <= no_phs;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_q    <= winner;
                        last_q     <= winner;
                        len_q      <= win_len;
                        cnt_q      <= '0;
                        phs_seen_q <= 1'b0;
                    end
                end
                STREAM:  cnt_q <= stream_last ? '0 : cnt_q + LEN_W'(1);
                GAP:     cnt_q <= cnt_q + LEN_W'(1);
                default: cnt_q <= '0;
            endcase
            // Only the first PHS strobe of a packet is kept.
            if (capture) begin
                phs_o      <= phs_i;
                phs_port_o <= grant_q;
                phs_seen_q <= 1'b1;
            end else if (no_phs) begin
                phs_port_o <= grant_q;
            end
        end
    end

endmodule

// File: doc/n3_parser_port_scheduler.md
# n3_parser_port_scheduler

Round-robin scheduler that shares one N3 GTP-U packet parser among NUM_PORTS ingress requesters. It grants one port at a time and streams that port's packet words onto the parser's 32-bit bus with a start-of-packet pulse. It then captures the parser's 15-byte PHS result and returns it tagged with the originating port. A packet that finishes without producing a PHS is flagged as an error.

## Interface
- NUM_PORTS, 4, number of requesters (2..16); PW = $clog2(NUM_PORTS)
- GAP_CYCLES, 2, idle cycles (bus driven to zero) inserted after each packet's last word (1..15)
- LEN_W, 16, width of packet length in 32-bit words

- CLK  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- req_i  in  NUM_PORTS  per-port request; packet fully buffered and available
- pkt_len_i  in  NUM_PORTS*LEN_W  per-port packet length in words; port p occupies slice [p*LEN_W +: LEN_W]
- data_i  in  NUM_PORTS*32  per-port show-ahead head word; port p occupies slice [p*32 +: 32]
- rd_o  out  NUM_PORTS  per-port word pop, one-hot or zero
- bus_o  out  32  word to parser bus
- sop_o  out  1  start-of-packet pulse to parser
- phs_i  in  120  PHS from parser
- phs_valid_i  in  1  PHS valid strobe from parser
- phs_o  out  120  captured PHS
- phs_port_o  out  PW  port that produced phs_o / err_nophs_o
- phs_valid_o  out  1  one-cycle PHS result strobe
- err_nophs_o  out  1  one-cycle strobe: packet ended without PHS
- busy_o  out  1  high in any state other than IDLE

## Operation
- States: IDLE, STREAM, GAP.
- Round-robin pointer last_q:
  - Reset value NUM_PORTS-1, so port 0 has first priority.
  - Search starts at last_q+1 and wraps modulo NUM_PORTS.
- **IDLE**
  - If any req_i is set: latch grant_q = winner, len_q = pkt_len_i[winner] (0 is treated as 1), last_q = winner, cnt_q = 0, phs_seen_q = 0.
  - Go to STREAM.
- **STREAM**
  - Driven outputs:
    - bus_o = data_i[grant_q]
    - rd_o[grant_q] = 1
    - sop_o = 1 only when cnt_q == 0
  - cnt_q increments each cycle.
  - When cnt_q == len_q-1: go to GAP with cnt_q = 0.
  - req_i is ignored after grant. The requester must present a valid word on every STREAM cycle.
- **GAP**
  - Driven outputs: bus_o = 0, rd_o = 0, sop_o = 0.
  - cnt_q increments each cycle.
  - When cnt_q == GAP_CYCLES-1: go to IDLE.
  - On that final GAP cycle, if phs_seen_q == 0 and phs_valid_i == 0: pulse err_nophs_o on the next cycle with phs_port_o = grant_q.
- **PHS capture**
  - Applies when phs_valid_i = 1 in STREAM or GAP and phs_seen_q == 0.
  - Next cycle: phs_o = phs_i, phs_port_o = grant_q, phs_valid_o = 1, and phs_seen_q is set.
  - Further strobes for the same packet are ignored.
  - A strobe in IDLE is ignored.
- bus_o, sop_o and rd_o are combinational from registered state. phs_o, phs_port_o, phs_valid_o and err_nophs_o are registered.
- phs_o and phs_port_o hold their last values until the next capture or error.
- Reset values: state IDLE; all outputs 0 (bus_o, sop_o, rd_o, phs_o, phs_port_o, phs_valid_o, err_nophs_o, busy_o).
- Reset asserted mid-packet aborts immediately. No err_nophs_o pulse and no PHS strobe are produced for the aborted packet.

## Timing
- req_i seen in IDLE at edge N: sop_o and the first word are on bus_o in cycle N+1.
- One packet occupies 1 (IDLE) + len + GAP_CYCLES cycles. Back-to-back packets are separated by exactly one IDLE cycle plus the gap.
- phs_valid_i at cycle M gives phs_valid_o at cycle M+1.
- err_nophs_o fires one cycle after the last GAP cycle, i.e. in the following IDLE/STREAM cycle.
- phs_valid_i arriving in the last GAP cycle counts as captured: phs_valid_o pulses and err_nophs_o does not.
- Length is sampled only at grant. Later changes to pkt_len_i have no effect on the packet in flight.

## Test plan
- **Single port.** Port 0 requests, len=20, GAP_CYCLES=2, parser strobes phs_valid_i at word 16 with phs_i=120'h03..AB.
  - sop_o high only in cycle 1; rd_o[0] high for 20 cycles.
  - phs_valid_o one cycle after the strobe with phs_o=120'h03..AB, phs_port_o=0.
  - busy_o low after 22 cycles.
- **Round robin.** All 4 ports request continuously, len=8 each.
  - Grant order 0,1,2,3,0.
  - Exactly one rd_o bit set during STREAM.
  - 1+8+2=11 cycles per packet.
- **No PHS.** Port 2 requests with len=12 and phs_valid_i is never asserted.
  - err_nophs_o pulses once with phs_port_o=2, one cycle after the final GAP cycle.
  - phs_valid_o stays 0.
- **Late PHS and duplicate strobe.** phs_valid_i is high in both the last STREAM cycle and the last GAP cycle.
  - Single phs_valid_o from the first strobe only.
  - err_nophs_o stays 0.
- **Zero length and wrap.** Port 3 has len=0 and is granted with last_q=2.
  - Exactly 1 word is streamed with sop_o.
  - The next grant goes to port 0.
- **Reset mid-stream.** reset asserted at word 5 of 20.
  - All outputs 0 asynchronously; no err_nophs_o pulse.
  - After release, port 0 is granted first.
